// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared defines for the memory bus arbiter: register-bus width, zero word,
//   reset level (active-low), stall-request levels and arbiter state encodings.
package mem_bus_arbiter_pkg;

    localparam int RegBus = 32;
    localparam logic [RegBus-1:0] ZeroWord = '0;

    // This block resets when rst is low.
    localparam logic RstEnable = 1'b0;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GNT_MEM = 2'd1,
        ARB_GNT_IF  = 2'd2,
        ARB_DRAIN   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog
//   Bus-cycle watchdog: counts cycles spent waiting for ack and flags expiry
//   once the count reaches TIMEOUT_CYC-1. Only built with ARB_TIMEOUT_EN.
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   i_clr      restart the count (arbiter idle or entering a new wait state)
//   i_active   a bus cycle is outstanding
//   i_ack      slave ack this cycle (ack always beats expiry)
//   o_expired  limit reached without ack
module arb_watchdog
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_active,
    input  logic i_ack,
    output logic o_expired
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_active && !i_ack && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expired = i_active && !i_ack && (r_cnt == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one external memory bus between the IF stage (instruction reads)
//   and the MEM stage (loads/stores). One registered bus cycle at a time,
//   MEM has fixed priority. Stall requests are held until each stage's access
//   completes; flush discards fetches cancelled by exceptions/eret.
//   Optional macro: ARB_TIMEOUT_EN adds a watchdog (arb_watchdog) that ends
//   a bus cycle after TIMEOUT_CYC cycles without ack and pulses bus_err.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   stall[5:0], flush     pipeline controller (bit1 = IF hold, bit4 = MEM hold)
//   if_req/if_addr        instruction fetch request; if_rdata, if_stallreq out
//   mem_req/we/sel/addr/wdata  data access request; mem_rdata, mem_stallreq out
//   bus_req/we/sel/addr/wdata  registered bus master outputs
//   bus_rdata, bus_ack    slave response
//   bus_err               one-cycle timeout pulse (0 without ARB_TIMEOUT_EN)
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DATA_W      = RegBus,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stallreq,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [3:0]        mem_sel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stallreq,
    output logic              bus_req,
    output logic              bus_we,
    output logic [3:0]        bus_sel,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err
);

    localparam logic [DATA_W-1:0] ZERO_D = DATA_W'(ZeroWord);

    arb_state_t        r_state,     w_state_nxt;
    logic              r_bus_req,   w_bus_req_nxt;
    logic              r_bus_we,    w_bus_we_nxt;
    logic [3:0]        r_bus_sel,   w_bus_sel_nxt;
    logic [ADDR_W-1:0] r_bus_addr,  w_bus_addr_nxt;
    logic [DATA_W-1:0] r_bus_wdata, w_bus_wdata_nxt;
    logic [DATA_W-1:0] r_if_rdata,  w_if_rdata_nxt;
    logic [DATA_W-1:0] r_mem_rdata, w_mem_rdata_nxt;
    logic              r_if_done,   w_if_done_nxt;
    logic              r_mem_done,  w_mem_done_nxt;
    logic              r_bus_err,   w_bus_err_nxt;
    logic              w_wd_expired;

    // Only the IF and MEM hold bits matter here.
    logic w_unused_stall;
    assign w_unused_stall = ^{stall[5], stall[3:2], stall[0]};

`ifdef ARB_TIMEOUT_EN
    // Count restarts while idle (covers entry to either grant) and on the
    // GNT_IF -> DRAIN hop, so DRAIN gets its own full window.
    logic w_wd_clr;
    logic w_wd_active;
    assign w_wd_clr    = (r_state == ARB_IDLE) ||
                         ((r_state == ARB_GNT_IF) && flush && !bus_ack);
    assign w_wd_active = (r_state != ARB_IDLE);

    arb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_wd_clr),
        .i_active  (w_wd_active),
        .i_ack     (bus_ack),
        .o_expired (w_wd_expired)
    );
`else
    assign w_wd_expired = 1'b0;
    logic w_unused_cfg;
    assign w_unused_cfg = ^TIMEOUT_CYC;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            r_state     <= ARB_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bus_req   <= w_bus_req_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_sel   <= w_bus_sel_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_mem_rdata <= w_mem_rdata_nxt;
            r_if_done   <= w_if_done_nxt;
            r_mem_done  <= w_mem_done_nxt;
            r_bus_err   <= w_bus_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bus_req_nxt   = r_bus_req;
        w_bus_we_nxt    = r_bus_we;
        w_bus_sel_nxt   = r_bus_sel;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_wdata_nxt = r_bus_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_mem_rdata_nxt = r_mem_rdata;
        w_bus_err_nxt   = 1'b0;
        // A done flag survives only while its stage is held; once the stage
        // advances the next request is a new access.
        w_if_done_nxt   = r_if_done  & stall[1];
        w_mem_done_nxt  = r_mem_done & stall[4];

        case (r_state)
            ARB_IDLE: begin
                if (mem_req && !r_mem_done) begin
                    w_state_nxt     = ARB_GNT_MEM;
                    w_bus_req_nxt   = 1'b1;
                    w_bus_we_nxt    = mem_we;
                    w_bus_sel_nxt   = mem_sel;
                    w_bus_addr_nxt  = mem_addr;
                    w_bus_wdata_nxt = mem_wdata;
                end else if (if_req && !r_if_done && !flush) begin
                    w_state_nxt     = ARB_GNT_IF;
                    w_bus_req_nxt   = 1'b1;
                    w_bus_we_nxt    = 1'b0;
                    w_bus_sel_nxt   = 4'b1111;
                    w_bus_addr_nxt  = if_addr;
                    w_bus_wdata_nxt = ZERO_D;
                end
            end
            ARB_GNT_MEM: begin
                // A data cycle cannot be aborted, so flush does not divert it.
                if (bus_ack) begin
                    w_state_nxt     = ARB_IDLE;
                    w_bus_req_nxt   = 1'b0;
                    w_mem_rdata_nxt = bus_rdata;
                    w_mem_done_nxt  = 1'b1;
                end else if (w_wd_expired) begin
                    w_state_nxt     = ARB_IDLE;
                    w_bus_req_nxt   = 1'b0;
                    w_bus_err_nxt   = 1'b1;
                    w_mem_rdata_nxt = ZERO_D;
                    w_mem_done_nxt  = 1'b1;
                end
            end
            ARB_GNT_IF: begin
                if (bus_ack) begin
                    w_state_nxt    = ARB_IDLE;
                    w_bus_req_nxt  = 1'b0;
                    w_if_rdata_nxt = bus_rdata;
                    w_if_done_nxt  = 1'b1;
                end else if (flush) begin
                    // Keep the cycle open until the slave acks, then drop it.
                    w_state_nxt = ARB_DRAIN;
                end else if (w_wd_expired) begin
                    w_state_nxt    = ARB_IDLE;
                    w_bus_req_nxt  = 1'b0;
                    w_bus_err_nxt  = 1'b1;
                    w_if_rdata_nxt = ZERO_D;
                    w_if_done_nxt  = 1'b1;
                end
            end
            ARB_DRAIN: begin
                if (bus_ack || w_wd_expired) begin
                    w_state_nxt   = ARB_IDLE;
                    w_bus_req_nxt = 1'b0;
                    w_bus_err_nxt = w_wd_expired;
                end
            end
            default: begin
                w_state_nxt   = ARB_IDLE;
                w_bus_req_nxt = 1'b0;
            end
        endcase

        // Flush wins over any completion this edge: data may still be
        // captured, but no stage is told its access finished.
        if (flush) begin
            w_if_done_nxt  = 1'b0;
            w_mem_done_nxt = 1'b0;
        end
    end

    assign if_stallreq  = (if_req  && !r_if_done)  ? Stop : NoStop;
    assign mem_stallreq = (mem_req && !r_mem_done) ? Stop : NoStop;

    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_sel   = r_bus_sel;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_stallreq;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_stallreq;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_stallreq  (if_stallreq),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_stallreq (mem_stallreq),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_sel      (bus_sel),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack),
        .bus_err      (bus_err)
    );

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic        if_req;
        logic [31:0] if_addr;
        logic        mem_req;
        logic        mem_we;
        logic [3:0]  mem_sel;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_ifr;
        logic [31:0] e_memr;
        logic        e_ifst;
        logic        e_memst;
    } vec_t;

    vec_t vt [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // one more unit later, well clear of the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 6'h00; flush = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
        bus_ack = 1'b0; bus_rdata = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // stall: 07 = IF held, 1F = MEM (and earlier) held, 00 = advancing
        vt[0]  = '{6'h07,1'b0,1'b1,32'h100,1'b0,1'b0,4'h0,32'h0,32'h0,1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,  32'h0,       32'h0,       32'h0,       1'b1,1'b0};
        vt[1]  = '{6'h07,1'b0,1'b1,32'h100,1'b0,1'b0,4'h0,32'h0,32'h0,1'b0,32'h0,        1'b1,1'b0,4'hF,32'h100,32'h0,       32'h0,       32'h0,       1'b1,1'b0};
        vt[2]  = '{6'h07,1'b0,1'b1,32'h100,1'b0,1'b0,4'h0,32'h0,32'h0,1'b0,32'h0,        1'b1,1'b0,4'hF,32'h100,32'h0,       32'h0,       32'h0,       1'b1,1'b0};
        vt[3]  = '{6'h07,1'b0,1'b1,32'h100,1'b0,1'b0,4'h0,32'h0,32'h0,1'b1,32'h24020001, 1'b1,1'b0,4'hF,32'h100,32'h0,       32'h0,       32'h0,       1'b1,1'b0};
        vt[4]  = '{6'h00,1'b0,1'b1,32'h100,1'b0,1'b0,4'h0,32'h0,32'h0,1'b0,32'h0,        1'b0,1'b0,4'hF,32'h100,32'h0,       32'h24020001,32'h0,       1'b0,1'b0};
        vt[5]  = '{6'h00,1'b0,1'b0,32'h100,1'b0,1'b0,4'h0,32'h0,32'h0,1'b0,32'h0,        1'b0,1'b0,4'hF,32'h100,32'h0,       32'h24020001,32'h0,       1'b0,1'b0};
        vt[6]  = '{6'h1F,1'b0,1'b1,32'h104,1'b1,1'b1,4'h3,32'h80,32'hDEADBEEF,1'b0,32'h0, 1'b0,1'b0,4'hF,32'h100,32'h0,       32'h24020001,32'h0,       1'b1,1'b1};
        vt[7]  = '{6'h1F,1'b0,1'b1,32'h104,1'b1,1'b1,4'h3,32'h80,32'hDEADBEEF,1'b1,32'h0, 1'b1,1'b1,4'h3,32'h80, 32'hDEADBEEF,32'h24020001,32'h0,       1'b1,1'b1};
        vt[8]  = '{6'h07,1'b0,1'b1,32'h104,1'b1,1'b1,4'h3,32'h80,32'hDEADBEEF,1'b0,32'h0, 1'b0,1'b1,4'h3,32'h80, 32'hDEADBEEF,32'h24020001,32'h0,       1'b1,1'b0};
        vt[9]  = '{6'h07,1'b0,1'b1,32'h104,1'b0,1'b0,4'h0,32'h0,32'h0,1'b0,32'h0,        1'b1,1'b0,4'hF,32'h104,32'h0,       32'h24020001,32'h0,       1'b1,1'b0};
        vt[10] = '{6'h07,1'b0,1'b1,32'h104,1'b0,1'b0,4'h0,32'h0,32'h0,1'b1,32'h8C220004, 1'b1,1'b0,4'hF,32'h104,32'h0,       32'h24020001,32'h0,       1'b1,1'b0};
        vt[11] = '{6'h00,1'b0,1'b1,32'h104,1'b0,1'b0,4'h0,32'h0,32'h0,1'b0,32'h0,        1'b0,1'b0,4'hF,32'h104,32'h0,       32'h8C220004,32'h0,       1'b0,1'b0};
        vt[12] = '{6'h1F,1'b0,1'b0,32'h104,1'b1,1'b0,4'hF,32'h200,32'h0,1'b0,32'h0,      1'b0,1'b0,4'hF,32'h104,32'h0,       32'h8C220004,32'h0,       1'b0,1'b1};
        vt[13] = '{6'h1F,1'b0,1'b0,32'h104,1'b1,1'b0,4'hF,32'h200,32'h0,1'b1,32'hCAFEF00D,1'b1,1'b0,4'hF,32'h200,32'h0,       32'h8C220004,32'h0,       1'b0,1'b1};
        vt[14] = '{6'h1F,1'b0,1'b0,32'h104,1'b1,1'b0,4'hF,32'h200,32'h0,1'b0,32'h12345678,1'b0,1'b0,4'hF,32'h200,32'h0,       32'h8C220004,32'hCAFEF00D,1'b0,1'b0};
        vt[15] = '{6'h1F,1'b0,1'b0,32'h104,1'b1,1'b0,4'hF,32'h200,32'h0,1'b0,32'h12345678,1'b0,1'b0,4'hF,32'h200,32'h0,       32'h8C220004,32'hCAFEF00D,1'b0,1'b0};
        vt[16] = '{6'h00,1'b0,1'b0,32'h104,1'b1,1'b0,4'hF,32'h200,32'h0,1'b0,32'h0,      1'b0,1'b0,4'hF,32'h200,32'h0,       32'h8C220004,32'hCAFEF00D,1'b0,1'b0};
        vt[17] = '{6'h1F,1'b0,1'b0,32'h104,1'b1,1'b0,4'hF,32'h204,32'h0,1'b0,32'h0,      1'b0,1'b0,4'hF,32'h200,32'h0,       32'h8C220004,32'hCAFEF00D,1'b0,1'b1};
        vt[18] = '{6'h1F,1'b0,1'b0,32'h104,1'b1,1'b0,4'hF,32'h204,32'h0,1'b1,32'hA5A5A5A5,1'b1,1'b0,4'hF,32'h204,32'h0,       32'h8C220004,32'hCAFEF00D,1'b0,1'b1};
        vt[19] = '{6'h00,1'b0,1'b0,32'h104,1'b0,1'b0,4'hF,32'h204,32'h0,1'b0,32'h0,      1'b0,1'b0,4'hF,32'h204,32'h0,       32'h8C220004,32'hA5A5A5A5,1'b0,1'b0};

        // Reset state
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("reset bus_req",   32'(bus_req),   32'h0);
        chk("reset bus_addr",  bus_addr,       32'h0);
        chk("reset bus_sel",   32'(bus_sel),   32'h0);
        chk("reset if_rdata",  if_rdata,       32'h0);
        chk("reset mem_rdata", mem_rdata,      32'h0);
        chk("reset bus_err",   32'(bus_err),   32'h0);
        rst = 1'b1;

        // Single fetch, simultaneous store+fetch, held load done
        for (int i = 0; i < 20; i++) begin
            stall = vt[i].stall; flush = vt[i].flush;
            if_req = vt[i].if_req; if_addr = vt[i].if_addr;
            mem_req = vt[i].mem_req; mem_we = vt[i].mem_we; mem_sel = vt[i].mem_sel;
            mem_addr = vt[i].mem_addr; mem_wdata = vt[i].mem_wdata;
            bus_ack = vt[i].ack; bus_rdata = vt[i].rdata;
            #1;
            chk($sformatf("row%0d bus_req", i),      32'(bus_req),      32'(vt[i].e_req));
            chk($sformatf("row%0d bus_we", i),       32'(bus_we),       32'(vt[i].e_we));
            chk($sformatf("row%0d bus_sel", i),      32'(bus_sel),      32'(vt[i].e_sel));
            chk($sformatf("row%0d bus_addr", i),     bus_addr,          vt[i].e_addr);
            chk($sformatf("row%0d bus_wdata", i),    bus_wdata,         vt[i].e_wdata);
            chk($sformatf("row%0d if_rdata", i),     if_rdata,          vt[i].e_ifr);
            chk($sformatf("row%0d mem_rdata", i),    mem_rdata,         vt[i].e_memr);
            chk($sformatf("row%0d if_stallreq", i),  32'(if_stallreq),  32'(vt[i].e_ifst));
            chk($sformatf("row%0d mem_stallreq", i), 32'(mem_stallreq), 32'(vt[i].e_memst));
            chk($sformatf("row%0d bus_err", i),      32'(bus_err),      32'h0);
            step();
        end

        // Flush during fetch: cycle drains, data discarded, refetch follows
        idle_inputs();
        if_req = 1'b1; if_addr = 32'h140; stall = 6'h07;
        step();
        flush = 1'b1;
        #1;
        chk("flush grant bus_req",  32'(bus_req), 32'h1);
        chk("flush grant bus_addr", bus_addr,     32'h140);
        step();
        flush = 1'b0; if_addr = 32'h180;
        #1;
        chk("drain bus_req",     32'(bus_req),     32'h1);
        chk("drain bus_addr",    bus_addr,         32'h140);
        chk("drain if_stallreq", 32'(if_stallreq), 32'h1);
        step();
        bus_ack = 1'b1; bus_rdata = 32'hBADBAD00;
        #1;
        chk("drain ack bus_req", 32'(bus_req), 32'h1);
        step();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        #1;
        chk("post drain bus_req",     32'(bus_req),     32'h0);
        chk("post drain if_rdata",    if_rdata,         32'h8C220004);
        chk("post drain if_stallreq", 32'(if_stallreq), 32'h1);
        step();
        bus_ack = 1'b1; bus_rdata = 32'h3C1D0000;
        #1;
        chk("refetch bus_req",  32'(bus_req), 32'h1);
        chk("refetch bus_addr", bus_addr,     32'h180);
        chk("refetch bus_we",   32'(bus_we),  32'h0);
        step();
        bus_ack = 1'b0; stall = 6'h00;
        #1;
        chk("refetch if_rdata",    if_rdata,         32'h3C1D0000);
        chk("refetch if_stallreq", 32'(if_stallreq), 32'h0);
        chk("refetch idle",        32'(bus_req),     32'h0);
        if_req = 1'b0;
        step();

        // Flush coincident with ack in GNT_MEM: data kept, done not set
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h300; stall = 6'h1F;
        step();
        bus_ack = 1'b1; bus_rdata = 32'h77778888; flush = 1'b1;
        #1;
        chk("memflush bus_addr", bus_addr, 32'h300);
        step();
        bus_ack = 1'b0; flush = 1'b0;
        #1;
        chk("memflush mem_rdata",    mem_rdata,         32'h77778888);
        chk("memflush mem_stallreq", 32'(mem_stallreq), 32'h1);
        chk("memflush bus_req",      32'(bus_req),      32'h0);
        mem_req = 1'b0; stall = 6'h00;
        step();

        // Reset mid-transaction
        if_req = 1'b1; if_addr = 32'h1C0; stall = 6'h07;
        step();
        #1;
        chk("midrst grant bus_req", 32'(bus_req), 32'h1);
        rst = 1'b0;
        #1;
        chk("midrst bus_req",   32'(bus_req), 32'h0);
        chk("midrst bus_addr",  bus_addr,     32'h0);
        chk("midrst if_rdata",  if_rdata,     32'h0);
        chk("midrst mem_rdata", mem_rdata,    32'h0);
        if_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("after rst if_stallreq",  32'(if_stallreq),  32'h0);
        chk("after rst mem_stallreq", 32'(mem_stallreq), 32'h0);
        step();
        chk("after rst no grant", 32'(bus_req), 32'h0);
        if_req = 1'b1; if_addr = 32'h1C4;
        #1;
        chk("new req if_stallreq", 32'(if_stallreq), 32'h1);
        step();
        chk("new req bus_req",  32'(bus_req), 32'h1);
        chk("new req bus_addr", bus_addr,     32'h1C4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
